deser400_serpar_mc: RTL and testbench

Multi-channel, parametrised serial-to-parallel converter for the 400 MHz serial input path. Each of CHANNELS serial lanes is shifted into a WIDTH-bit word. Each lane independently finds its word boundary by hunting for a sync pattern, then confirms it over LOCK_COUNT consecutive words. Aligned words are presented on a flat parallel bus with a per-lane write strobe, for the downstream clock-domain FIFO and readout logic.

---
 rtl/deser400_pkg.sv | 17 +
 rtl/deser400_lane.sv | 147 ++++++++++++++
 rtl/deser400_serpar_mc.sv | 38 +++
 tb/tb_deser400_serpar_mc.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/deser400_pkg.sv
// Shared types, default constants and width helper for the deser400 converter.
package deser400_pkg;

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        LOCKED
    } lane_state_t;

    localparam logic [15:0] SYNC_PATTERN_DEFAULT = 16'h7FFE;

    // Bits needed for a counter that must hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/deser400_lane.sv
// One deser400 lane: shift register, bit counter, alignment FSM and word output.
// DESER400_ALIGN_EN selects sync-pattern alignment; otherwise the boundary is fixed at reset.
//
//   state  | meaning
//   HUNT   | sliding compare of every incoming word against the sync pattern
//   CHECK  | boundary found, confirming sync on each following word boundary
//   LOCKED | aligned, words emitted on boundaries while run is high
module deser400_lane
    import deser400_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] SYNC_PATTERN = WIDTH'(SYNC_PATTERN_DEFAULT),
    parameter int               LOCK_COUNT   = 3
) (
    input  logic             clk400,
    input  logic             reset,
    input  logic             run,
    input  logic             realign,
    input  logic             ser,
    output logic [WIDTH-1:0] par,
    output logic             write,
    output logic             locked
);

    localparam int            CW       = cnt_width(WIDTH - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] par_q, par_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             write_q, write_d;
    logic [WIDTH-1:0] word;
    logic [CW-1:0]    cnt_inc;
    logic             boundary;

    assign word     = {shreg_q[WIDTH-2:0], ser};
    assign boundary = (cnt_q == CNT_LAST);
    assign cnt_inc  = boundary ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clk400) begin
        if (reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            par_q   <= '0;
            write_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            write_q <= write_d;
        end
    end

`ifdef DESER400_ALIGN_EN
    localparam int            MW         = cnt_width(LOCK_COUNT);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT);

    lane_state_t   state_q, state_d;
    logic [MW-1:0] match_q, match_d;
    logic          sync_hit;

    assign sync_hit = (word == SYNC_PATTERN);

    always_comb begin
        shreg_d = word;
        cnt_d   = cnt_inc;
        state_d = state_q;
        match_d = match_q;
        par_d   = par_q;
        write_d = 1'b0;
        // realign overrides any boundary or sync match on the same edge
        if (realign) begin
            state_d = HUNT;
            cnt_d   = '0;
            match_d = '0;
        end else begin
            case (state_q)
                HUNT: begin
                    if (sync_hit) begin
                        cnt_d   = '0;
                        match_d = MW'(1);
                        state_d = (LOCK_COUNT == 1) ? LOCKED : CHECK;
                    end
                end
                CHECK: begin
                    if (boundary) begin
                        if (sync_hit) begin
                            match_d = match_q + MW'(1);
                            if (match_d == MATCH_LAST) state_d = LOCKED;
                        end else begin
                            match_d = '0;
                            state_d = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    if (boundary && run) begin
                        par_d   = word;
                        write_d = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk400) begin
        if (reset) begin
            state_q <= HUNT;
            match_q <= '0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
        end
    end

    assign locked = (state_q == LOCKED);
`else
    logic locked_q, locked_d;
    logic unused_cfg;

    assign unused_cfg = &{1'b0, realign, SYNC_PATTERN, LOCK_COUNT[0]};

    always_comb begin
        shreg_d  = word;
        cnt_d    = cnt_inc;
        par_d    = par_q;
        write_d  = 1'b0;
        locked_d = 1'b1;
        if (boundary && run) begin
            par_d   = word;
            write_d = 1'b1;
        end
    end

    always_ff @(posedge clk400) begin
        if (reset) locked_q <= 1'b0;
        else       locked_q <= locked_d;
    end

    assign locked = locked_q;
`endif

    assign par   = par_q;
    assign write = write_q;

endmodule

// File: rtl/deser400_serpar_mc.sv
// Multi-lane 400 MHz serial-to-parallel converter; one deser400_lane per serial input.
// Alignment behaviour is selected inside the lane by DESER400_ALIGN_EN.
module deser400_serpar_mc
    import deser400_pkg::*;
#(
    parameter int               CHANNELS     = 2,
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] SYNC_PATTERN = WIDTH'(SYNC_PATTERN_DEFAULT),
    parameter int               LOCK_COUNT   = 3
) (
    input  logic                      clk400,
    input  logic                      reset,
    input  logic                      run,
    input  logic                      realign,
    input  logic [CHANNELS-1:0]       ser,
    output logic [CHANNELS*WIDTH-1:0] par,
    output logic [CHANNELS-1:0]       write,
    output logic [CHANNELS-1:0]       locked
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        deser400_lane #(
            .WIDTH       (WIDTH),
            .SYNC_PATTERN(SYNC_PATTERN),
            .LOCK_COUNT  (LOCK_COUNT)
        ) u_lane (
            .clk400 (clk400),
            .reset  (reset),
            .run    (run),
            .realign(realign),
            .ser    (ser[c]),
            .par    (par[c*WIDTH +: WIDTH]),
            .write  (write[c]),
            .locked (locked[c])
        );
    end

endmodule

// File: tb/tb_deser400_serpar_mc.sv
// Self-checking bench for deser400_serpar_mc: per-lane bit streams are built from
// words, and expected write/par/locked timelines are derived from word positions.
module tb_deser400_serpar_mc;

    localparam int CH = 2;
    localparam int W  = 16;
    localparam int N  = 1000;
    localparam logic [W-1:0] SYNC = 16'h7FFE;

    logic              clk400  = 1'b0;
    logic              reset   = 1'b1;
    logic              run     = 1'b0;
    logic              realign = 1'b0;
    logic [CH-1:0]     ser     = '0;
    logic [CH*W-1:0]   par;
    logic [CH-1:0]     write;
    logic [CH-1:0]     locked;

    always #5 clk400 = ~clk400;

    deser400_serpar_mc #(
        .CHANNELS    (CH),
        .WIDTH       (W),
        .SYNC_PATTERN(SYNC),
        .LOCK_COUNT  (3)
    ) dut (
        .clk400 (clk400),
        .reset  (reset),
        .run    (run),
        .realign(realign),
        .ser    (ser),
        .par    (par),
        .write  (write),
        .locked (locked)
    );

    // stimulus per edge index t (edge 0 = first rising edge after reset release)
    bit             stream    [CH][N];
    bit             run_t     [N];
    bit             realign_t [N];
    // expectation after edge t
    bit             exp_wr    [CH][N];
    logic [W-1:0]   exp_word  [CH][N];
    bit             exp_lk    [CH][N];

    int checks = 0;
    int errors = 0;

    logic [W-1:0]    cur [CH];
    logic [CH-1:0]   ew, el;
    logic [CH*W-1:0] ep;

    function automatic void put_word(input int c, input int s, input logic [W-1:0] wd);
        for (int i = 0; i < W; i++)
            if (s + i < N) stream[c][s+i] = wd[W-1-i];
    endfunction

    // word on an aligned lane: emitted on its last bit edge when run is high there
    function automatic void data_word(input int c, input int s, input logic [W-1:0] wd);
        put_word(c, s, wd);
        if (s + W - 1 < N && run_t[s+W-1]) begin
            exp_wr[c][s+W-1]   = 1'b1;
            exp_word[c][s+W-1] = wd;
        end
    endfunction

    function automatic void set_lock(input int c, input int from, input int to);
        for (int t = from; t < to && t < N; t++) exp_lk[c][t] = 1'b1;
    endfunction

    // random payload with bits 15 and 7 clear: no run of 1s long enough to look like sync
    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] r;
        r    = 16'($urandom);
        r[15] = 1'b0;
        r[7]  = 1'b0;
        return r;
    endfunction

    task automatic drive(input int t);
        for (int c = 0; c < CH; c++) ser[c] = stream[c][t];
        run     = run_t[t];
        realign = realign_t[t];
    endtask

    initial begin
        for (int t = 0; t < N; t++) begin
            run_t[t]     = !(t >= 300 && t < 340);
            realign_t[t] = 1'b0;
        end

`ifdef DESER400_ALIGN_EN
        realign_t[473] = 1'b1;
        // lane 0: sync at phase 10, lock on edge 57, data until realign at its boundary 473
        for (int k = 0; k < 3; k++) put_word(0, 10 + 16*k, SYNC);
        set_lock(0, 57, 473);
        data_word(0, 58, 16'h1234);
        for (int k = 1; k < 25; k++) data_word(0, 58 + 16*k, rnd_word());
        put_word(0, 58 + 16*25, rnd_word());
        // lane 0 re-lock 7 bits later in phase
        for (int k = 0; k < 3; k++) put_word(0, 497 + 16*k, SYNC);
        set_lock(0, 544, N);
        for (int s = 545; s + W <= N; s += W) data_word(0, s, rnd_word());

        // lane 1: 5 bits behind lane 0
        for (int k = 0; k < 3; k++) put_word(1, 15 + 16*k, SYNC);
        set_lock(1, 62, 473);
        for (int k = 0; k < 25; k++) data_word(1, 63 + 16*k, rnd_word());
        put_word(1, 63 + 16*25, rnd_word());
        // sync, corrupted word, then a clean 3x sync
        put_word(1, 490, SYNC);
        put_word(1, 506, 16'h7FFF);
        for (int k = 0; k < 3; k++) put_word(1, 550 + 16*k, SYNC);
        set_lock(1, 597, N);
        for (int s = 598; s + W <= N; s += W) data_word(1, s, rnd_word());
`else
        realign_t[47]  = 1'b1;
        realign_t[200] = 1'b1;
        for (int s = 0; s + W <= N; s += W) begin
            data_word(0, s, 16'hA5A5);
            data_word(1, s, 16'($urandom));
        end
        set_lock(0, 0, N);
        set_lock(1, 0, N);
`endif

        reset = 1'b1;
        repeat (3) @(posedge clk400);
        @(negedge clk400);
        checks++;
        assert (write === '0) else begin
            errors++; $error("FAIL reset_write got %b exp %b", write, {CH{1'b0}});
        end
        checks++;
        assert (locked === '0) else begin
            errors++; $error("FAIL reset_locked got %b exp %b", locked, {CH{1'b0}});
        end
        checks++;
        assert (par === '0) else begin
            errors++; $error("FAIL reset_par got %h exp %h", par, {CH*W{1'b0}});
        end

        for (int c = 0; c < CH; c++) cur[c] = '0;
        reset = 1'b0;
        drive(0);
        for (int t = 0; t < N; t++) begin
            @(negedge clk400);
            for (int c = 0; c < CH; c++) begin
                ew[c] = exp_wr[c][t];
                el[c] = exp_lk[c][t];
                if (exp_wr[c][t]) cur[c] = exp_word[c][t];
                ep[c*W +: W] = cur[c];
            end
            checks++;
            assert (write === ew) else begin
                errors++; $error("FAIL write t=%0d got %b exp %b", t, write, ew);
            end
            checks++;
            assert (locked === el) else begin
                errors++; $error("FAIL locked t=%0d got %b exp %b", t, locked, el);
            end
            checks++;
            assert (par === ep) else begin
                errors++; $error("FAIL par t=%0d got %h exp %h", t, par, ep);
            end
            if (t + 1 < N) drive(t + 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
